pc_fetch_unit: RTL and testbench

Program-counter and fetch sequencer for the single-cycle MIPS datapath. It sits directly upstream of the word-addressed instruction memory: it drives the byte address into that memory and takes back the 32-bit instruction. From that instruction and the ALU branch condition it computes the next PC (sequential, beq/bne, j). It also provides stall, halt-on-end-of-program and a retired-instruction counter.

---
 rtl/pc_fetch_unit.sv | 109 ++++++++++
 tb/tb_pc_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer for a single-cycle MIPS datapath.
// Drives the instruction-memory byte address, decodes beq/bne/j from the
// returned word to form the next PC, and tracks stall, halt and retired count.
module pc_fetch_unit #(
  parameter int unsigned       ADDR_W       = 8,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter bit                HALT_ON_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              branch_cond,
  input  logic              stall,
  output logic [ADDR_W-1:0] read_addr,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              instr_valid,
  output logic              halted,
  output logic [15:0]       retired
);

  localparam logic [1:0] StBoot = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHalt = 2'd2;

  localparam logic [5:0] OpBeq = 6'b000100;
  localparam logic [5:0] OpBne = 6'b000101;
  localparam logic [5:0] OpJ   = 6'b000010;

  localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(4);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       retired_q, retired_d;

  logic [5:0]        op;
  logic [15:0]       imm;
  logic              halt_cond;
  logic              is_j;
  logic              br_taken;
  logic [31:0]       br_off;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;
  logic              unused_bits;

  // Decode and candidate targets, all combinational from the fetched word.
  always_comb begin
    op        = instruction[31:26];
    imm       = instruction[15:0];
    halt_cond = HALT_ON_ZERO && (instruction == 32'h0);
    is_j      = (op == OpJ);
    br_taken  = ((op == OpBeq) && branch_cond) || ((op == OpBne) && !branch_cond);
    br_off    = {{14{imm[15]}}, imm, 2'b00};
    // Truncation to ADDR_W gives the modulo-2^ADDR_W wrap in both directions.
    br_target = pc_plus4 + br_off[ADDR_W-1:0];
    j_target  = {instruction[ADDR_W-3:0], 2'b00};
  end

  // Sink for instruction/offset bits that don't reach the address path.
  assign unused_bits = ^{instruction, br_off};

  assign read_addr   = pc_q;
  assign pc_plus4    = pc_q + PcStep;
  assign instr_valid = (state_q == StRun) && !stall && !halt_cond;
  assign halted      = (state_q == StHalt);
  assign retired     = retired_q;

  // Next-state: sequencer state, PC selection and saturating retire count.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (halt_cond) begin
          state_d = StHalt;
        end else if (!stall) begin
          if (is_j) begin
            pc_d = j_target;
          end else if (br_taken) begin
            pc_d = br_target;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      StHalt: state_d = StHalt;
      // Unreachable encoding: park in HALT until reset.
      default: state_d = StHalt;
    endcase
    if (instr_valid && (retired_q != 16'hFFFF)) begin
      retired_d = retired_q + 16'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StBoot;
      pc_q      <= RESET_PC;
      retired_q <= 16'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: two instances differing only in
// HALT_ON_ZERO share the same instruction stream.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic        branch_cond;
  logic        stall;

  logic [7:0]  read_addr0, pc_plus40, read_addr1, pc_plus41;
  logic        instr_valid0, halted0, instr_valid1, halted1;
  logic [15:0] retired0, retired1;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] Addi = 32'h20080020;

  pc_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .HALT_ON_ZERO(1'b1)) dut0 (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .branch_cond (branch_cond),
    .stall       (stall),
    .read_addr   (read_addr0),
    .pc_plus4    (pc_plus40),
    .instr_valid (instr_valid0),
    .halted      (halted0),
    .retired     (retired0)
  );

  pc_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .HALT_ON_ZERO(1'b0)) dut1 (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .branch_cond (branch_cond),
    .stall       (stall),
    .read_addr   (read_addr1),
    .pc_plus4    (pc_plus41),
    .instr_valid (instr_valid1),
    .halted      (halted1),
    .retired     (retired1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    stall       = 1'b0;
    branch_cond = 1'b0;
    instruction = Addi;

    // Reset edge -> BOOT
    tick();
    check("rst_addr", 32'(read_addr0), 32'h00);
    check("rst_plus4", 32'(pc_plus40), 32'h04);
    check("rst_valid", 32'(instr_valid0), 32'h0);
    check("rst_halted", 32'(halted0), 32'h0);
    check("rst_retired", 32'(retired0), 32'h0);

    // BOOT -> RUN, first executed instruction at 0x00
    reset = 1'b1;
    tick();
    check("run0_addr", 32'(read_addr0), 32'h00);
    check("run0_valid", 32'(instr_valid0), 32'h1);
    check("run0_retired", 32'(retired0), 32'h0);
    tick();
    check("seq_addr4", 32'(read_addr0), 32'h04);
    check("seq_ret1", 32'(retired0), 32'h1);
    tick();
    check("seq_addr8", 32'(read_addr0), 32'h08);
    check("seq_ret2", 32'(retired0), 32'h2);
    tick();
    check("seq_ret3", 32'(retired0), 32'h3);
    tick();
    check("pre_stall_addr", 32'(read_addr0), 32'h10);

    // Stall three cycles at 0x10
    stall = 1'b1;
    #1;
    check("stall_valid", 32'(instr_valid0), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", 32'(read_addr0), 32'h10);
      check("stall_ret", 32'(retired0), 32'h4);
    end
    stall = 1'b0;
    tick();
    check("post_stall_addr", 32'(read_addr0), 32'h14);
    check("post_stall_ret", 32'(retired0), 32'h5);
    tick();
    tick();
    tick();
    check("at_20", 32'(read_addr0), 32'h20);

    // beq not taken
    instruction = 32'h12320009;
    branch_cond = 1'b0;
    #1;
    check("beq_plus4", 32'(pc_plus40), 32'h24);
    tick();
    check("beq_nt", 32'(read_addr0), 32'h24);
    // j back to 0x20, then beq taken
    instruction = 32'h08000008;
    tick();
    check("j_20a", 32'(read_addr0), 32'h20);
    instruction = 32'h12320009;
    branch_cond = 1'b1;
    tick();
    check("beq_t", 32'(read_addr0), 32'h48);
    check("beq_t_ret", 32'(retired0), 32'd11);
    // back to 0x20, bne taken with cond=0
    instruction = 32'h08000008;
    tick();
    instruction = 32'h16320009;
    branch_cond = 1'b0;
    tick();
    check("bne_t", 32'(read_addr0), 32'h48);
    // j to 0x44, then j 0x0800000E
    instruction = 32'h08000011;
    tick();
    check("j_44", 32'(read_addr0), 32'h44);
    instruction = 32'h0800000E;
    tick();
    check("j_38", 32'(read_addr0), 32'h38);
    // non-branch with cond=1 stays sequential
    instruction = Addi;
    branch_cond = 1'b1;
    tick();
    check("dc_cond", 32'(read_addr0), 32'h3C);
    instruction = 32'h1280000F;
    tick();
    check("beq_7c", 32'(read_addr0), 32'h7C);
    check("beq_7c_ret", 32'(retired0), 32'd17);

    // Zero word at 0x7C
    instruction = 32'h0;
    branch_cond = 1'b0;
    #1;
    check("zero_valid0", 32'(instr_valid0), 32'h0);
    check("zero_valid1", 32'(instr_valid1), 32'h1);
    check("zero_halted_pre", 32'(halted0), 32'h0);
    tick();
    check("halt_flag", 32'(halted0), 32'h1);
    check("halt_addr", 32'(read_addr0), 32'h7C);
    check("halt_ret", 32'(retired0), 32'd17);
    check("nohalt_addr", 32'(read_addr1), 32'h80);
    check("nohalt_ret", 32'(retired1), 32'd18);
    check("nohalt_flag", 32'(halted1), 32'h0);

    // HALT ignores branches and stall
    instruction = 32'h12320009;
    branch_cond = 1'b1;
    stall = 1'b1;
    tick();
    check("halt_hold_addr", 32'(read_addr0), 32'h7C);
    check("halt_hold_flag", 32'(halted0), 32'h1);
    check("halt_hold_valid", 32'(instr_valid0), 32'h0);

    // Reset while halted
    reset = 1'b0;
    tick();
    check("rst_halt_addr", 32'(read_addr0), 32'h00);
    check("rst_halt_plus4", 32'(pc_plus40), 32'h04);
    check("rst_halt_flag", 32'(halted0), 32'h0);
    check("rst_halt_ret", 32'(retired0), 32'h0);
    check("rst_halt_valid", 32'(instr_valid0), 32'h0);
    reset = 1'b1;
    tick();
    check("boot_stall_addr", 32'(read_addr0), 32'h00);
    stall = 1'b0;
    branch_cond = 1'b0;

    // Wrap: jump to 0xFC, sequential wraps to 0x00
    instruction = 32'h0800003F;
    tick();
    check("j_fc", 32'(read_addr0), 32'hFC);
    check("fc_plus4", 32'(pc_plus40), 32'h00);
    instruction = Addi;
    tick();
    check("wrap_seq", 32'(read_addr0), 32'h00);
    tick();
    check("at_04", 32'(read_addr0), 32'h04);
    instruction = 32'h1000FFFE;
    branch_cond = 1'b1;
    tick();
    check("neg_br_00", 32'(read_addr0), 32'h00);
    tick();
    check("neg_br_wrap", 32'(read_addr0), 32'hFC);
    check("neg_br_ret", 32'(retired0), 32'h5);

    // Reset during stall
    stall = 1'b1;
    tick();
    check("stall_fc", 32'(read_addr0), 32'hFC);
    reset = 1'b0;
    tick();
    check("rst_stall_addr", 32'(read_addr0), 32'h00);
    check("rst_stall_ret", 32'(retired0), 32'h0);
    check("rst_stall_valid", 32'(instr_valid0), 32'h0);
    check("rst_stall_plus4", 32'(pc_plus40), 32'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
